// File: rtl/regfile_rp.sv
// MIPS-style register file: one write port and RD_PORTS registered read ports; reg 0 reads as zero.
// Define RF_BYPASS_EN to forward same-edge write data to matching read ports.
module regfile_rp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int RD_PORTS = 2,
  parameter logic [DATA_W-1:0] GP_RESET = 32'h1000_8000,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h7FFF_EFFC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_valid,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data
);

  if (NUM_REGS > 2**ADDR_W || RD_PORTS < 1) begin : g_param_err
    $error("regfile_rp: NUM_REGS must be <= 2**ADDR_W and RD_PORTS >= 1");
  end

  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_ok;

  always_comb begin
    w_wr_ok = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < LP_NREGS);
  end

  // Per-entry address decode keeps index widths exact for any NUM_REGS <= 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (NUM_REGS > 29 && k == 28)      r_regs[k] <= GP_RESET;
        else if (NUM_REGS > 29 && k == 29) r_regs[k] <= SP_RESET;
        else                               r_regs[k] <= '0;
      end
    end else begin
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
        if (w_wr_ok && wr_addr == ADDR_W'(k)) r_regs[k] <= wr_data;
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Address 0 and unimplemented addresses fall through to the zero default.
    always_comb begin
      w_word = '0;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
        if (w_addr == ADDR_W'(k)) w_word = r_regs[k];
      end
`ifdef RF_BYPASS_EN
      if (w_wr_ok && wr_addr == w_addr) w_word = wr_data;
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= rd_en[p];
        if (rd_en[p]) r_data <= w_word;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = r_data;
    assign rd_valid[p]                 = r_valid;
  end

endmodule

// File: tb/tb_regfile_rp.sv
// Bench for regfile_rp: a 32-register and a 16-register instance share stimulus and
// are checked against an array-based model of the register file.
module tb_regfile_rp;

  localparam logic [31:0] GP = 32'h1000_8000;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_valid, b_rd_valid;

  logic [63:0] obs_data  [2];
  logic [1:0]  obs_valid [2];
  assign obs_data[0]  = a_rd_data;
  assign obs_data[1]  = b_rd_data;
  assign obs_valid[0] = a_rd_valid;
  assign obs_valid[1] = b_rd_valid;

  // Reference state: register contents and expected outputs per instance.
  logic [31:0] m_reg   [2][32];
  logic [31:0] m_data  [2][2];
  logic [1:0]  m_valid [2];
  int          nregs   [2] = '{32, 16};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_rp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .RD_PORTS(2)) u_dut32 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  regfile_rp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .RD_PORTS(2)) u_dut16 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  // Apply the current inputs to the model, then advance one clock and settle.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 32; k++) m_reg[d][k] = 32'h0;
        if (nregs[d] > 29) begin
          m_reg[d][28] = GP;
          m_reg[d][29] = SP;
        end
        m_data[d][0] = 32'h0;
        m_data[d][1] = 32'h0;
        m_valid[d]   = 2'b00;
      end else begin
        for (int p = 0; p < 2; p++) begin
          int a;
          a = int'(rd_addr[p*5 +: 5]);
          m_valid[d][p] = rd_en[p];
          if (rd_en[p]) begin
            if (a == 0 || a >= nregs[d]) m_data[d][p] = 32'h0;
`ifdef RF_BYPASS_EN
            else if (wr_en && int'(wr_addr) == a) m_data[d][p] = wr_data;
`endif
            else m_data[d][p] = m_reg[d][a];
          end
        end
        if (wr_en && wr_addr != 5'd0 && int'(wr_addr) < nregs[d]) m_reg[d][wr_addr] = wr_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rd_en = 2'b00; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd28; wr_data = $urandom;
    rd_en = 2'b11; rd_addr = {5'd29, 5'd28};
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d] !== 64'h0 || obs_valid[d] !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_out dut%0d: got data=%h valid=%b want 0/00", d, obs_data[d], obs_valid[d]);
      end
    end
    idle(); rd_en = 2'b11; rd_addr = {5'd29, 5'd28};
    tick();
    n_checks++;
    if (a_rd_data !== {SP, GP} || a_rd_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_gp_sp dut32: got data=%h valid=%b want %h/11", a_rd_data, a_rd_valid, {SP, GP});
    end
    n_checks++;
    if (b_rd_data !== 64'h0 || b_rd_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_gp_sp dut16: got data=%h valid=%b want 0/11", b_rd_data, b_rd_valid);
    end
    rd_addr = {5'd5, 5'd5};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d] !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_reg5 dut%0d: got %h want 0", d, obs_data[d]);
      end
    end
  endtask

  task automatic test_basic_rw();
    idle(); wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
    tick();
    idle(); rd_en = 2'b11; rd_addr = {5'd8, 5'd8};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d] !== {2{32'hDEAD_BEEF}} || obs_valid[d] !== 2'b11) begin
        n_fail++;
        $display("FAIL basic_read dut%0d: got %h/%b want deadbeef x2/11", d, obs_data[d], obs_valid[d]);
      end
    end
    idle();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d] !== {2{32'hDEAD_BEEF}} || obs_valid[d] !== 2'b00) begin
        n_fail++;
        $display("FAIL basic_valid_drop dut%0d: got %h/%b want deadbeef x2/00", d, obs_data[d], obs_valid[d]);
      end
    end
  endtask

  task automatic test_zero_reg();
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    rd_en = 2'b01; rd_addr = {5'd8, 5'd0};
    tick();
    idle(); rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d] !== 64'h0 || obs_valid[d] !== 2'b11) begin
        n_fail++;
        $display("FAIL zero_reg dut%0d: got %h/%b want 0/11", d, obs_data[d], obs_valid[d]);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_same;
`ifdef RF_BYPASS_EN
    exp_same = 32'h2222_2222;
`else
    exp_same = 32'h1111_1111;
`endif
    idle(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1111_1111;
    tick();
    wr_data = 32'h2222_2222; rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d][31:0] !== exp_same || obs_data[d][31:0] !== m_data[d][0]) begin
        n_fail++;
        $display("FAIL collision_same dut%0d: got %h want %h", d, obs_data[d][31:0], exp_same);
      end
    end
    idle(); rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d] !== {2{32'h2222_2222}}) begin
        n_fail++;
        $display("FAIL collision_next dut%0d: got %h want 22222222 x2", d, obs_data[d]);
      end
    end
  endtask

  task automatic test_hold_reset();
    idle(); wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hABCD_0001;
    tick();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd11};
    tick();
    idle(); rd_addr = 10'($urandom);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d][31:0] !== 32'hABCD_0001 || obs_valid[d] !== 2'b00) begin
        n_fail++;
        $display("FAIL hold dut%0d: got %h/%b want abcd0001/00", d, obs_data[d][31:0], obs_valid[d]);
      end
    end
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h5;
    rd_en = 2'b11; rd_addr = {5'd11, 5'd10};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d] !== 64'h0 || obs_valid[d] !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_priority dut%0d: got %h/%b want 0/00", d, obs_data[d], obs_valid[d]);
      end
    end
    idle(); rd_en = 2'b11; rd_addr = {5'd11, 5'd10};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_data[d] !== 64'h0) begin
        n_fail++;
        $display("FAIL rst_drops_write dut%0d: got %h want 0", d, obs_data[d]);
      end
    end
  endtask

  task automatic test_out_of_range();
    idle(); wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h7;
    tick();
    idle(); rd_en = 2'b11; rd_addr = {5'd20, 5'd20};
    tick();
    n_checks++;
    if (b_rd_data !== 64'h0) begin
      n_fail++;
      $display("FAIL oor_read dut16: got %h want 0", b_rd_data);
    end
    n_checks++;
    if (a_rd_data !== {2{32'h7}}) begin
      n_fail++;
      $display("FAIL oor_read dut32: got %h want 7 x2", a_rd_data);
    end
    for (int k = 0; k < 16; k += 2) begin
      rd_addr = {5'(k + 1), 5'(k)};
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_data[d] !== {m_data[d][1], m_data[d][0]}) begin
          n_fail++;
          $display("FAIL oor_scan dut%0d regs %0d/%0d: got %h want %h", d, k, k + 1,
                   obs_data[d], {m_data[d][1], m_data[d][0]});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rd_en   = 2'($urandom);
      rd_addr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr[9:5] = rd_addr[4:0];
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_data[d] !== {m_data[d][1], m_data[d][0]} || obs_valid[d] !== m_valid[d]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc %0d: got %h/%b want %h/%b", d, i, obs_data[d],
                   obs_valid[d], {m_data[d][1], m_data[d][0]}, m_valid[d]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rd_en = 2'b00; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_basic_rw();
    test_zero_reg();
    test_collision();
    test_hold_reset();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_rp.md
Name: regfile_rp

Overview:
- Parametrised MIPS-style general-purpose register file with one synchronous write port and RD_PORTS independently enabled, registered read ports.
- Replaces the flat combinational 32-input register select in the datapath.
- Sits between decode (read addresses), writeback (write port) and the operand latches feeding the ALU and DMA address logic.
- Register 0 is hardwired to zero; $gp and $sp take ABI reset values.

Parameters:
- DATA_W, 32, register and data-bus width in bits.
- ADDR_W, 5, register-address width.
- NUM_REGS, 32, implemented registers; must be no greater than 2**ADDR_W.
- RD_PORTS, 2, number of read ports; must be at least 1.
- GP_RESET, 32'h1000_8000, reset value of register 28 ($gp).
- SP_RESET, 32'h7FFF_EFFC, reset value of register 29 ($sp).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_en  in  RD_PORTS  per-port read request.
- rd_addr  in  RD_PORTS*ADDR_W  per-port address; port i occupies slice [i*ADDR_W +: ADDR_W].
- rd_data  out  RD_PORTS*DATA_W  per-port registered read data; same slicing by DATA_W.
- rd_valid  out  RD_PORTS  per-port flag: rd_data updated on this edge.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.

Behaviour:
- Reset, on a clk edge with rst=1:
  - All registers clear to 0, except reg 28 = GP_RESET and reg 29 = SP_RESET (when NUM_REGS > 29).
  - rd_data all 0; rd_valid all 0.
  - rst has priority over any concurrent write or read on the same edge.
  - rst asserted mid-stream discards that cycle's write and reads.
- Write:
  - On an edge with wr_en=1, rst=0, wr_addr != 0 and wr_addr < NUM_REGS, reg[wr_addr] <= wr_data.
  - Writes to address 0 or to any address >= NUM_REGS are silently dropped.
- Read:
  - Latency 1 cycle.
  - On an edge with rd_en[i]=1, rd_data[i] <= reg[rd_addr[i]].
  - Address 0 always returns 0. Address >= NUM_REGS returns 0.
  - rd_valid[i] <= rd_en[i] every non-reset edge.
  - With rd_en[i]=0, rd_data[i] holds its previous value and rd_valid[i] falls to 0.
- Ports are fully independent.
  - Any number of ports may read the same address on the same edge; all receive identical data.
- Same-edge read and write to the same nonzero address: the read returns the pre-write value unless RF_BYPASS_EN is defined (see Optional Feature).
- No handshake back-pressure: every request completes in exactly one cycle.
- No state machine beyond the register array and output registers. Throughput is one write plus RD_PORTS reads per cycle.
- Parameter checks: elaboration fails (generate-time error) if NUM_REGS > 2**ADDR_W or RD_PORTS < 1.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: on an edge where wr_en=1, wr_addr == rd_addr[i] != 0, wr_addr < NUM_REGS and rd_en[i]=1, rd_data[i] <= wr_data (write-through forwarding). Applies to every matching port simultaneously. Address 0 is never forwarded.
- Undefined: no forwarding. A same-edge read returns the old register contents; the new value is visible from the following edge.

Test Plan:
1. Reset values: assert rst 2 cycles, then read port0 addr 28 and port1 addr 29 -> next edge rd_data0=32'h1000_8000, rd_data1=32'h7FFF_EFFC, rd_valid=2'b11. Also read addr 5 -> 0.
2. Basic write/read: write reg 8 = 32'hDEAD_BEEF; next cycle read reg 8 on both ports -> both rd_data=32'hDEAD_BEEF one cycle after rd_en; rd_valid high for exactly one cycle.
3. Zero register: write reg 0 = 32'hFFFF_FFFF, then read addr 0 -> 0. With RF_BYPASS_EN, a same-edge read of addr 0 is also 0.
4. Same-edge collision: reg 9 = 32'h1111_1111; write 32'h2222_2222 to reg 9 while reading 9 on port0 -> rd_data0=32'h1111_1111 without the macro, 32'h2222_2222 with it. Read on the following cycle -> 32'h2222_2222 in both builds.
5. Hold and reset priority:
   - Deassert rd_en after a read of 32'hABCD_0001 -> rd_data holds 32'hABCD_0001, rd_valid=0.
   - Assert rst together with a wr_en to reg 10 = 32'h5 -> reg 10 reads 0 afterwards and rd_data=0.
6. Out-of-range: NUM_REGS=16, ADDR_W=5; write addr 20 = 32'h7 then read addr 20 -> 0, and regs 0..15 unchanged.
